vx_tc_bus_arb: RTL

//  N-to-1 arbiter for tensor-core memory buses: merges NUM_REQS master-side tc bus channels (req addr/tag,
//  rsp data/tag) onto one slave-side channel toward the L1/memory. Round-robin request grant, channel index

---
 rtl/vx_tc_pkg.sv | 16 +
 rtl/vx_tc_elastic_buf.sv | 58 +++++
 rtl/vx_tc_bus_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vx_tc_pkg.sv
// Shared constants and helpers for the tensor-core bus arbiter slice.
package vx_tc_pkg;

  localparam int TC_ADDR_WIDTH = 32;

  // Width of an index signal that must stay at least one bit wide.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Channel index lives in the MSBs of the merged tag, directly above the per-channel tag.
  function automatic int chan_idx_lsb(input int tag_width);
    return tag_width;
  endfunction

endpackage

// File: rtl/vx_tc_elastic_buf.sv
// Two-entry elastic buffer: 1-cycle latency, full throughput, ready driven purely from state.
module vx_tc_elastic_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             in_ready_reg;
  logic             push;
  logic             pop;

  assign push      = in_valid && in_ready_reg;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count_reg != 2'd0);
  assign in_ready  = in_ready_reg;
  assign out_data  = mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Ready is registered from the next occupancy, so it stays low while reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      in_ready_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg    <= count_next;
      in_ready_reg <= (count_next != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= in_data;
  end

endmodule

// File: rtl/vx_tc_bus_arb.sv
// N-to-1 tensor-core bus arbiter: round-robin request merge with per-channel credits,
// channel index prepended to the tag, responses steered back combinationally by tag.
module vx_tc_bus_arb
  import vx_tc_pkg::*;
#(
  parameter int NUM_REQS        = 4,
  parameter int DATA_SIZE       = 32,
  parameter int ADDR_WIDTH      = TC_ADDR_WIDTH,
  parameter int TAG_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int LOG_REQS       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int OUT_TAG_W      = TAG_WIDTH + LOG_REQS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQS-1:0]             in_req_valid,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]  in_req_addr,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   in_req_tag,
  output logic [NUM_REQS-1:0]             in_req_ready,
  output logic [NUM_REQS-1:0]             in_rsp_valid,
  output logic [NUM_REQS*DATA_SIZE*8-1:0] in_rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]   in_rsp_tag,
  input  logic [NUM_REQS-1:0]             in_rsp_ready,
  output logic                            out_req_valid,
  output logic [ADDR_WIDTH-1:0]           out_req_addr,
  output logic [OUT_TAG_W-1:0]            out_req_tag,
  input  logic                            out_req_ready,
  input  logic                            out_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]          out_rsp_data,
  input  logic [OUT_TAG_W-1:0]            out_rsp_tag,
  output logic                            out_rsp_ready,
  output logic                            err_underflow
);

  localparam int CH_W     = clog2_min1(NUM_REQS);
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int DATA_W   = DATA_SIZE * 8;
  localparam int CHAN_LSB = chan_idx_lsb(TAG_WIDTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [OUT_TAG_W-1:0]  tag;
  } tc_req_t;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [OUT_TAG_W-1:0] tag;
  } tc_rsp_t;

  logic [CNT_W-1:0]     cnt_reg [NUM_REQS];
  logic [CH_W-1:0]      rr_reg;
  logic                 err_reg;
  logic [NUM_REQS-1:0]  eligible;
  logic [NUM_REQS-1:0]  req_fire_vec;
  logic [NUM_REQS-1:0]  rsp_fire_vec;
  logic                 grant_valid;
  logic [CH_W-1:0]      grant_idx;
  logic [CH_W-1:0]      scan_idx;
  logic                 buf_in_ready;
  logic                 req_fire;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic [OUT_TAG_W-1:0] grant_tag;
  tc_req_t              grant_req;
  tc_req_t              out_req;
  tc_rsp_t              rsp;
  logic [CH_W-1:0]      rsp_ch;

  assign rsp = '{data: out_rsp_data, tag: out_rsp_tag};

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_chan
    assign eligible[gi]     = in_req_valid[gi] && (cnt_reg[gi] < CNT_W'(MAX_OUTSTANDING));
    assign in_req_ready[gi] = grant_valid && (grant_idx == CH_W'(gi)) && buf_in_ready;
    assign req_fire_vec[gi] = in_req_valid[gi] && in_req_ready[gi];
    assign in_rsp_valid[gi] = out_rsp_valid && (rsp_ch == CH_W'(gi));
    assign rsp_fire_vec[gi] = in_rsp_valid[gi] && in_rsp_ready[gi];
    assign in_rsp_tag[gi*TAG_WIDTH +: TAG_WIDTH] = rsp.tag[TAG_WIDTH-1:0];
    assign in_rsp_data[gi*DATA_W +: DATA_W]      = rsp.data;
  end

  // Scan from the highest offset down so the closest eligible channel after rr_reg wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      scan_idx = CH_W'((int'(rr_reg) + k) % NUM_REQS);
      if (eligible[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign req_fire = grant_valid && buf_in_ready;
  assign sel_tag  = in_req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];

  if (NUM_REQS > 1) begin : g_multi
    assign grant_tag = {grant_idx, sel_tag};
    assign rsp_ch    = rsp.tag[CHAN_LSB +: LOG_REQS];
  end else begin : g_single
    assign grant_tag = sel_tag;
    assign rsp_ch    = '0;
  end

  assign grant_req     = '{addr: in_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH], tag: grant_tag};
  assign out_rsp_ready = (int'(rsp_ch) < NUM_REQS) ? in_rsp_ready[rsp_ch] : 1'b0;
  assign err_underflow = err_reg;

  // Credits are taken at input accept, so buffered requests already count as outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_reg  <= '0;
      err_reg <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) cnt_reg[i] <= '0;
    end else begin
      if (req_fire) rr_reg <= (grant_idx == CH_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_fire_vec[i] && !rsp_fire_vec[i]) begin
          cnt_reg[i] <= cnt_reg[i] + 1'b1;
        end else if (!req_fire_vec[i] && rsp_fire_vec[i]) begin
          if (cnt_reg[i] == '0) err_reg <= 1'b1;
          else                  cnt_reg[i] <= cnt_reg[i] - 1'b1;
        end
      end
    end
  end

  vx_tc_elastic_buf #(
    .WIDTH($bits(tc_req_t))
  ) u_req_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (grant_valid),
    .in_ready  (buf_in_ready),
    .in_data   (grant_req),
    .out_valid (out_req_valid),
    .out_ready (out_req_ready),
    .out_data  (out_req)
  );

  assign out_req_addr = out_req.addr;
  assign out_req_tag  = out_req.tag;

endmodule
